scroll_engine: RTL

Executes scroll-region requests issued by the cursor controller against the character text RAM. It moves whole lines up or down inside the region [top, bottom] and fills the vacated lines with a blank cell. It also services a full-screen clear. It sits between the parser's scrolling request outputs and the write port of the text buffer shared with the renderer.

---
 rtl/scroll_engine_if.sv | 28 ++
 rtl/scroll_engine.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/scroll_engine_if.sv
// scroll_engine_if: scroll/clear request, status and text-RAM port bundle.
// slave = scroll_engine side; master = requester plus text RAM side.
interface scroll_engine_if #(parameter int CELL_WIDTH = 16);
  logic                  scroll_valid;
  logic                  scroll_dir;
  logic [7:0]            scroll_step;
  logic [7:0]            scroll_top;
  logic [7:0]            scroll_bottom;
  logic                  clear_all;
  logic                  busy;
  logic                  done;
  logic                  dropped;
  logic [7:0]            ram_rline;
  logic [7:0]            ram_rcol;
  logic [CELL_WIDTH-1:0] ram_rdata;
  logic                  ram_wen;
  logic [7:0]            ram_wline;
  logic [7:0]            ram_wcol;
  logic [CELL_WIDTH-1:0] ram_wdata;
  modport slave (
    input  scroll_valid, scroll_dir, scroll_step, scroll_top, scroll_bottom, clear_all, ram_rdata,
    output busy, done, dropped, ram_rline, ram_rcol, ram_wen, ram_wline, ram_wcol, ram_wdata
  );
  modport master (
    output scroll_valid, scroll_dir, scroll_step, scroll_top, scroll_bottom, clear_all, ram_rdata,
    input  busy, done, dropped, ram_rline, ram_rcol, ram_wen, ram_wline, ram_wcol, ram_wdata
  );
endinterface

// File: rtl/scroll_engine.sv
// scroll_engine: shifts lines of the text RAM inside [top, bottom] and services full-screen clear.
// Optional SCROLL_BLANK_FILL_EN: vacated lines are written with BLANK_CELL; otherwise they keep stale data.
module scroll_engine #(
  parameter int                    CONSOLE_LINES   = 30,
  parameter int                    CONSOLE_COLUMNS = 80,
  parameter int                    CELL_WIDTH      = 16,
  parameter logic [CELL_WIDTH-1:0] BLANK_CELL      = 16'h0020
) (
  input logic            clk,
  input logic            rst_n,
  scroll_engine_if.slave bus
);
`ifdef SCROLL_BLANK_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif
  localparam logic [7:0] LINES    = 8'(CONSOLE_LINES);
  localparam logic [7:0] LAST_COL = 8'(CONSOLE_COLUMNS - 1);
  typedef enum logic [1:0] {IDLE, COPY, CLEAR, DONE} state_t;
  state_t     state_q, state_d;
  logic       dir_q, dir_d, drain_q, drain_d, wv_q, wv_d, dropped_q, dropped_d;
  logic [7:0] top_q, top_d, bot_q, bot_d, step_q, step_d, ncopy_q, ncopy_d, nclear_q, nclear_d;
  logic [7:0] idx_q, idx_d, col_q, col_d, wline_q, wline_d, wcol_q, wcol_d;
  logic [7:0] eff_step, height, dst, src, clr_line;
  logic       req, bad, big, rd_on, clearing;

  assign req      = bus.scroll_valid | bus.clear_all;
  assign eff_step = bus.scroll_step == 8'd0 ? 8'd1 : bus.scroll_step;
  assign height   = bus.scroll_bottom - bus.scroll_top + 8'd1;
  assign bad      = bus.scroll_top > bus.scroll_bottom || bus.scroll_bottom >= LINES;
  assign big      = eff_step >= height;
  // idx never exceeds n_copy-1, so src stays inside the region without wrapping
  assign dst      = dir_q ? bot_q - idx_q : top_q + idx_q;
  assign src      = dir_q ? dst - step_q : dst + step_q;
  assign clr_line = (dir_q ? top_q : bot_q - nclear_q + 8'd1) + idx_q;
  assign rd_on    = state_q == COPY && !drain_q;
  assign clearing = state_q == CLEAR;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    top_d     = top_q;
    bot_d     = bot_q;
    step_d    = step_q;
    ncopy_d   = ncopy_q;
    nclear_d  = nclear_q;
    idx_d     = idx_q;
    col_d     = col_q;
    drain_d   = drain_q;
    dropped_d = dropped_q;
    wv_d      = rd_on;
    wline_d   = rd_on ? dst : 8'd0;
    wcol_d    = rd_on ? col_q : 8'd0;
    case (state_q)
      IDLE: if (req) begin
        dropped_d = 1'b0;
        idx_d     = 8'd0;
        col_d     = 8'd0;
        drain_d   = 1'b0;
        if (bus.clear_all) begin
          dir_d    = 1'b1;
          top_d    = 8'd0;
          bot_d    = LINES - 8'd1;
          step_d   = LINES;
          ncopy_d  = 8'd0;
          nclear_d = LINES;
          state_d  = FILL_EN ? CLEAR : DONE;
        end else begin
          dir_d    = bus.scroll_dir;
          top_d    = bus.scroll_top;
          bot_d    = bus.scroll_bottom;
          step_d   = eff_step;
          ncopy_d  = big ? 8'd0 : height - eff_step;
          nclear_d = big ? height : eff_step;
          state_d  = bad ? DONE : !big ? COPY : FILL_EN ? CLEAR : DONE;
        end
      end
      COPY: if (drain_q) begin
        drain_d = 1'b0;
        idx_d   = 8'd0;
        col_d   = 8'd0;
        state_d = FILL_EN ? CLEAR : DONE;
      end else if (col_q == LAST_COL) begin
        col_d   = 8'd0;
        drain_d = idx_q == ncopy_q - 8'd1;
        idx_d   = idx_q == ncopy_q - 8'd1 ? idx_q : idx_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
      CLEAR: if (col_q == LAST_COL) begin
        col_d   = 8'd0;
        idx_d   = idx_q + 8'd1;
        state_d = idx_q == nclear_q - 8'd1 ? DONE : CLEAR;
      end else begin
        col_d = col_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && req) dropped_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      drain_q   <= 1'b0;
      wv_q      <= 1'b0;
      dropped_q <= 1'b0;
      top_q     <= 8'd0;
      bot_q     <= 8'd0;
      step_q    <= 8'd0;
      ncopy_q   <= 8'd0;
      nclear_q  <= 8'd0;
      idx_q     <= 8'd0;
      col_q     <= 8'd0;
      wline_q   <= 8'd0;
      wcol_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      drain_q   <= drain_d;
      wv_q      <= wv_d;
      dropped_q <= dropped_d;
      top_q     <= top_d;
      bot_q     <= bot_d;
      step_q    <= step_d;
      ncopy_q   <= ncopy_d;
      nclear_q  <= nclear_d;
      idx_q     <= idx_d;
      col_q     <= col_d;
      wline_q   <= wline_d;
      wcol_q    <= wcol_d;
    end
  end

  assign bus.busy      = state_q != IDLE;
  assign bus.done      = state_q == DONE;
  assign bus.dropped   = dropped_q;
  assign bus.ram_rline = rd_on ? src : 8'd0;
  assign bus.ram_rcol  = rd_on ? col_q : 8'd0;
  // copy writes forward the RAM's registered read data straight onto the write port
  assign bus.ram_wen   = wv_q | clearing;
  assign bus.ram_wline = clearing ? clr_line : wline_q;
  assign bus.ram_wcol  = clearing ? col_q : wcol_q;
  assign bus.ram_wdata = clearing ? BLANK_CELL : wv_q ? bus.ram_rdata : '0;
endmodule
